// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light sequencer and its monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tail_light_pkg;

  // Light bus patterns, bit order LC LB LA RA RB RC (bit 5 down to bit 0)
  localparam logic [5:0] LG_OFF = 6'b000000;
  localparam logic [5:0] LG_L1  = 6'b001000;
  localparam logic [5:0] LG_L2  = 6'b011000;
  localparam logic [5:0] LG_L3  = 6'b111000;
  localparam logic [5:0] LG_R1  = 6'b000100;
  localparam logic [5:0] LG_R2  = 6'b000110;
  localparam logic [5:0] LG_R3  = 6'b000111;
  localparam logic [5:0] LG_HAZ = 6'b111111;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_START = 2'd1,
    ERR_BAD_STEP  = 2'd2,
    ERR_NO_GAP    = 2'd3
  } err_code_t;

endpackage

// File: rtl/tail_light_monitor_if.sv
// Observation bus between the light sequencer side and the monitor.
// Latency: n/a (wiring only).
// Backpressure: none; the monitor observes lg every cycle.
interface tail_light_monitor_if
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic [5:0]       lg;
  logic             clr;
  mode_t            mode;
  logic             done;
  mode_t            done_type;
  logic             err;
  err_code_t        err_code;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] haz_cnt;
  logic [CNT_W-1:0] err_cnt;

  // Side driving the lights and reading back the verdicts
  modport master (
    output lg, clr,
    input  mode, done, done_type, err, err_code,
    input  left_cnt, right_cnt, haz_cnt, err_cnt
  );

  // Monitor side
  modport slave (
    input  lg, clr,
    output mode, done, done_type, err, err_code,
    output left_cnt, right_cnt, haz_cnt, err_cnt
  );
endinterface

// File: rtl/tail_light_monitor_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible one cycle after inc; clr wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at the maximum, clear takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/tail_light_monitor.sv
// Passive checker of the tail-light bus: tracks left/right/hazard sequences.
// Latency: lg sampled at edge k, state/pulses/counters visible after edge k.
// Backpressure: none; every sample is evaluated, no stalls.
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  tail_light_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L2, S_R1, S_R2, S_W1, S_W2, S_GAP
  } state_t;

  state_t    state_q, state_d, idle_d, ok_next;
  logic      idle_bad;
  logic [5:0] exp_lg;
  logic      is_final;
  mode_t     fin_type;
  logic      done_d, err_d;
  mode_t     dtype_d;
  err_code_t ecode_d;
  mode_t     mode_q, dtype_q;
  logic      done_q, err_q;
  err_code_t ecode_q;

  function automatic mode_t mode_of(state_t s);
    case (s)
      S_L1, S_L2: mode_of = MODE_LEFT;
      S_R1, S_R2: mode_of = MODE_RIGHT;
      S_W1, S_W2: mode_of = MODE_HAZ;
      default:    mode_of = MODE_IDLE;
    endcase
  endfunction

  // How a sample would be judged from IDLE; reused by the GAP and mismatch paths
  always_comb begin
    idle_d   = S_IDLE;
    idle_bad = 1'b0;
    case (bus.lg)
      LG_OFF:  idle_d = S_IDLE;
      LG_L1:   idle_d = S_L1;
      LG_R1:   idle_d = S_R1;
      LG_HAZ:  idle_d = S_W1;
      default: idle_bad = 1'b1;
    endcase
  end

  // Expected pattern and successor for each mid-sequence state
  always_comb begin
    exp_lg   = LG_OFF;
    ok_next  = S_IDLE;
    is_final = 1'b0;
    fin_type = MODE_IDLE;
    case (state_q)
      S_L1: begin exp_lg = LG_L2;  ok_next = S_L2; end
      S_L2: begin exp_lg = LG_L3;  ok_next = S_GAP; is_final = 1'b1; fin_type = MODE_LEFT;  end
      S_R1: begin exp_lg = LG_R2;  ok_next = S_R2; end
      S_R2: begin exp_lg = LG_R3;  ok_next = S_GAP; is_final = 1'b1; fin_type = MODE_RIGHT; end
      S_W1: begin exp_lg = LG_OFF; ok_next = S_W2; end
      S_W2: begin exp_lg = LG_HAZ; ok_next = S_GAP; is_final = 1'b1; fin_type = MODE_HAZ;   end
      default: ;
    endcase
  end

  // Next state plus done/err verdict for the current sample
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dtype_d = MODE_IDLE;
    err_d   = 1'b0;
    ecode_d = ERR_NONE;
    if (state_q == S_IDLE) begin
      state_d = idle_d;
      if (idle_bad) begin
        err_d   = 1'b1;
        ecode_d = ERR_BAD_START;
      end
    end else if (state_q == S_GAP) begin
      state_d = idle_d;
      if (bus.lg != LG_OFF) begin
        err_d   = 1'b1;
        ecode_d = ERR_NO_GAP;
      end
    end else if (bus.lg == exp_lg) begin
      state_d = ok_next;
      done_d  = is_final;
      dtype_d = fin_type;
    end else begin
      state_d = idle_d;
      err_d   = 1'b1;
      ecode_d = ERR_BAD_STEP;
    end
  end

  // State and registered outputs; reset drops any sequence in flight silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_IDLE;
      done_q  <= 1'b0;
      dtype_q <= MODE_IDLE;
      err_q   <= 1'b0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_of(state_d);
      done_q  <= done_d;
      dtype_q <= dtype_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.done      = done_q;
  assign bus.done_type = dtype_q;
  assign bus.err       = err_q;
  assign bus.err_code  = ecode_q;

  sat_counter #(.W(CNT_W)) u_left_cnt (
    .clk(clk), .reset(reset), .clr(bus.clr),
    .inc(done_d && (dtype_d == MODE_LEFT)), .q(bus.left_cnt)
  );

  sat_counter #(.W(CNT_W)) u_right_cnt (
    .clk(clk), .reset(reset), .clr(bus.clr),
    .inc(done_d && (dtype_d == MODE_RIGHT)), .q(bus.right_cnt)
  );

  sat_counter #(.W(CNT_W)) u_haz_cnt (
    .clk(clk), .reset(reset), .clr(bus.clr),
    .inc(done_d && (dtype_d == MODE_HAZ)), .q(bus.haz_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .clr(bus.clr),
    .inc(err_d), .q(bus.err_cnt)
  );

endmodule
